// File: rtl/ser_mux.sv
`default_nettype none
// ser_mux: parallel-to-serial word transmitter, LSB first, with bit index and write strobe per bit.
// Rev 1.0
module ser_mux #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] in_word_i,
    input  logic             in_valid_i,
    input  logic             hold_i,
    output logic             ready_o,
    output logic             out_o,
    output logic [CNT_W-1:0] count_o,
    output logic             wr_en_o,
    output logic             done_o
);

    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_SHIFT = 2'd1;
    localparam logic [1:0]       S_FIN   = 2'd2;
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             out_q,    out_d;
    logic             wr_en_q,  wr_en_d;
    logic             done_q,   done_d;
    logic             ready_q,  ready_d;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        out_d    = out_q;
        wr_en_d  = wr_en_q;
        done_d   = done_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    shadow_d = in_word_i;
                    count_d  = '0;
                    out_d    = in_word_i[0];
                    wr_en_d  = !hold_i;
                    ready_d  = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A bit is retired only on an edge where it was actually strobed,
                // so HOLD can delay but never skip or repeat an index.
                if (wr_en_q) begin
                    if (count_q == C_LAST) begin
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        count_d = w_count_inc;
                        out_d   = shadow_q[w_count_inc];
                        wr_en_d = !hold_i;
                    end
                end else begin
                    wr_en_d = !hold_i;
                end
            end
            S_FIN: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                wr_en_d = 1'b0;
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            count_q  <= '0;
            out_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            out_q    <= out_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign out_o   = out_q;
    assign count_o = count_q;
    assign wr_en_o = wr_en_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire
